alu_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit ALU datapath (AND/OR/XOR/ADD gate units). It accepts operation requests from two clients, grants the ALU round-robin, drives opcode and operands onto the ALU, captures the ALU result and returns it to the winning client over a valid/ack handshake. It sits between the ALU and its clients, such as the decode stage and a test/DMA port. The ALU itself is external and purely combinational.

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-client round-robin arbiter and sequencer for the shared
// combinational ALU. It latches the winning client's operands, drives them
// to the ALU for one cycle, then captures the result and holds it for that
// client until the client acks it.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   op0,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  input  logic             rack0,
  input  logic             rack1,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_r2,
  output logic [WIDTH-1:0] alu_r3,
  input  logic [WIDTH-1:0] alu_r1,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   any_req;
  logic   winner;
  logic   owner_ack;

  // Pick the winner: a lone requester wins; on a tie, the client that was
  // not granted last time wins.
  always_comb begin
    any_req = req0 | req1;
    winner  = 1'b0;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = 1'b1;
    end
    owner_ack = owner ? rack1 : rack0;
  end

  assign busy = (state != IDLE);

  // Sequencer: grant and latch in IDLE, capture the ALU result in EXEC,
  // hold the response in RESP until the owner acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      alu_op     <= '0;
      alu_r2     <= '0;
      alu_r3     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= EXEC;
            owner      <= winner;
            last_grant <= winner;
            gnt0       <= ~winner;
            gnt1       <= winner;
            alu_op     <= winner ? op1 : op0;
            alu_r2     <= winner ? a1 : a0;
            alu_r3     <= winner ? b1 : b0;
          end
        end
        EXEC: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          if (owner) begin
            rdata1  <= alu_r1;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= alu_r1;
            rvalid0 <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (owner_ack) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
